pwm_angle_decoder: RTL

// - Servo-PWM receiver: measures the high time and period of one servo pulse train and converts the high time back to a 0..180 deg angle.
// - Inverse of the servo PWM generator; uses the same 20 ms frame and 0.5..2.5 ms pulse mapping.
// - Sits on a GPIO input and is used for loopback checking of our own servo outputs or for reading an external RC receiver channel.

---
 rtl/pwm_angle_decoder.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_angle_decoder.sv
// Servo-PWM receiver: measures pulse high time and period and converts the high time to 0..180 deg.
// Optional glitch filter on the synchronised input is enabled with `define PWM_DECODE_FILTER_EN.
module pwm_angle_decoder #(
  parameter int unsigned PERIOD_CLKS = 1000000,
  parameter int unsigned DEG_MIN     = 25000,
  parameter int unsigned DEG_MAX     = 125000,
  parameter int unsigned PULSE_TOL   = 2500,
  parameter int unsigned PERIOD_TOL  = 100000,
  parameter int unsigned LOCK_CNT    = 3,
  parameter int unsigned FILTER_LEN  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [7:0]  angle,
  output logic [31:0] pulse_clks,
  output logic        angle_valid,
  output logic        locked,
  output logic        pulse_err,
  output logic        period_err,
  output logic        timeout
);

  localparam int unsigned STEP = (DEG_MAX - DEG_MIN) / 180;
  localparam logic [31:0] STEP_W  = 32'(STEP);
  localparam logic [31:0] HALF_W  = 32'(STEP / 2);
  localparam logic [31:0] MIN_W   = 32'(DEG_MIN);
  localparam logic [31:0] SPAN_W  = 32'(DEG_MAX - DEG_MIN);
  localparam logic [31:0] HI_MIN  = 32'(DEG_MIN - PULSE_TOL);
  localparam logic [31:0] HI_MAX  = 32'(DEG_MAX + PULSE_TOL);
  localparam logic [31:0] PER_MIN = 32'(PERIOD_CLKS - PERIOD_TOL);
  localparam logic [31:0] PER_MAX = 32'(PERIOD_CLKS + PERIOD_TOL);
  localparam logic [7:0]  ANG_MAX = 8'd180;
  localparam int unsigned GW = (LOCK_CNT > 0) ? $clog2(LOCK_CNT + 1) : 1;
  localparam logic [GW-1:0] LOCK_W = GW'(LOCK_CNT);

  typedef enum logic [1:0] {WAIT_RISE, HIGH, LOW} state_t;

  logic sync1_q, sync2_q, lvl, prev_q, prev_d, rise, fall;

  always_ff @(posedge clk) begin
    sync1_q <= pwm_in;
    sync2_q <= sync1_q;
  end

`ifdef PWM_DECODE_FILTER_EN
  localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  logic           filt_q, filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (32'(filt_cnt_q) >= FILTER_LEN - 1) filt_d = sync2_q;
      else filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  // prev resets high so a level already high at reset release is never taken as a rise
  assign prev_d = lvl;
  assign rise   = lvl & ~prev_q;
  assign fall   = ~lvl & prev_q;

  state_t        state_q, state_d;
  logic [31:0]   high_cnt_q, high_cnt_d, period_cnt_q, period_cnt_d;
  logic [GW-1:0] good_q, good_d;
  logic          busy_q, busy_d;
  logic [7:0]    q_q, q_d;
  logic [31:0]   rem_q, rem_d, conv_pulse_q, conv_pulse_d;
  logic [7:0]    angle_q, angle_d;
  logic [31:0]   pulse_clks_q, pulse_clks_d;
  logic          angle_valid_d, pulse_err_d, period_err_d, timeout_d;
  logic          angle_valid_q, pulse_err_q, period_err_q, timeout_q;
  logic          hi_ok, per_ok, to_hit;
  logic [31:0]   num;

  always_comb begin
    hi_ok  = (high_cnt_q >= HI_MIN) && (high_cnt_q <= HI_MAX);
    per_ok = (period_cnt_q >= PER_MIN) && (period_cnt_q <= PER_MAX);
    to_hit = (state_q != WAIT_RISE) && (period_cnt_q >= PER_MAX);
    if (high_cnt_q < MIN_W)                   num = '0;
    else if (high_cnt_q - MIN_W > SPAN_W)     num = SPAN_W;
    else                                      num = high_cnt_q - MIN_W;
  end

  always_comb begin
    state_d       = state_q;
    high_cnt_d    = (high_cnt_q != '1) ? high_cnt_q + 32'd1 : high_cnt_q;
    period_cnt_d  = (period_cnt_q != '1) ? period_cnt_q + 32'd1 : period_cnt_q;
    good_d        = good_q;
    busy_d        = busy_q;
    q_d           = q_q;
    rem_d         = rem_q;
    conv_pulse_d  = conv_pulse_q;
    angle_d       = angle_q;
    pulse_clks_d  = pulse_clks_q;
    angle_valid_d = 1'b0;
    pulse_err_d   = 1'b0;
    period_err_d  = 1'b0;
    timeout_d     = 1'b0;

    // Divider by repeated subtraction; the result register lags the finish decision by one cycle
    if (busy_q) begin
      if ((rem_q >= STEP_W) && (q_q < ANG_MAX)) begin
        rem_d = rem_q - STEP_W;
        q_d   = q_q + 8'd1;
      end else begin
        busy_d        = 1'b0;
        angle_d       = ((rem_q >= HALF_W) && (q_q < ANG_MAX)) ? q_q + 8'd1 : q_q;
        pulse_clks_d  = conv_pulse_q;
        angle_valid_d = 1'b1;
      end
    end

    unique case (state_q)
      WAIT_RISE: begin
        if (rise) begin
          state_d      = HIGH;
          high_cnt_d   = 32'd1;
          period_cnt_d = 32'd1;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d = LOW;
          if (!hi_ok) begin
            pulse_err_d = 1'b1;
            good_d      = '0;
          end else if (busy_q) begin
            pulse_err_d = 1'b1;
          end else begin
            busy_d       = 1'b1;
            q_d          = '0;
            rem_d        = num;
            conv_pulse_d = high_cnt_q;
          end
        end else if (to_hit) begin
          timeout_d = 1'b1;
          good_d    = '0;
          state_d   = WAIT_RISE;
        end
      end
      LOW: begin
        if (rise) begin
          state_d      = HIGH;
          high_cnt_d   = 32'd1;
          period_cnt_d = 32'd1;
          // A rise coinciding with timeout restarts measurement as a first rise
          if (to_hit) begin
            good_d = '0;
          end else if (!per_ok) begin
            period_err_d = 1'b1;
            good_d       = '0;
          end else if (good_q != LOCK_W) begin
            good_d = good_q + 1'b1;
          end
        end else if (to_hit) begin
          timeout_d = 1'b1;
          good_d    = '0;
          state_d   = WAIT_RISE;
        end
      end
      default: state_d = WAIT_RISE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q        <= 1'b1;
      state_q       <= WAIT_RISE;
      high_cnt_q    <= '0;
      period_cnt_q  <= '0;
      good_q        <= '0;
      busy_q        <= 1'b0;
      q_q           <= '0;
      rem_q         <= '0;
      conv_pulse_q  <= '0;
      angle_q       <= '0;
      pulse_clks_q  <= '0;
      angle_valid_q <= 1'b0;
      pulse_err_q   <= 1'b0;
      period_err_q  <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      prev_q        <= prev_d;
      state_q       <= state_d;
      high_cnt_q    <= high_cnt_d;
      period_cnt_q  <= period_cnt_d;
      good_q        <= good_d;
      busy_q        <= busy_d;
      q_q           <= q_d;
      rem_q         <= rem_d;
      conv_pulse_q  <= conv_pulse_d;
      angle_q       <= angle_d;
      pulse_clks_q  <= pulse_clks_d;
      angle_valid_q <= angle_valid_d;
      pulse_err_q   <= pulse_err_d;
      period_err_q  <= period_err_d;
      timeout_q     <= timeout_d;
    end
  end

  assign angle       = angle_q;
  assign pulse_clks  = pulse_clks_q;
  assign angle_valid = angle_valid_q;
  assign locked      = (good_q == LOCK_W);
  assign pulse_err   = pulse_err_q;
  assign period_err  = period_err_q;
  assign timeout     = timeout_q;

endmodule
